// File: rtl/crc_check.sv
// Serial CRC-8 receiver check: absorbs a qualified payload stream into an LFSR,
// then compares the following 8 serial CRC bits (LSB first) and reports a sticky mismatch.
module crc_check #(
  parameter logic [7:0] SEED = 8'hD8,
  parameter logic [7:0] TAPS = 8'b1001_0001
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA,
  input  logic       ACTIVE,
  input  logic       CRC_IN,
  input  logic       CRC_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       CRC_ERR,
  output logic [1:0] state_dbg,
  output logic [2:0] bit_cnt_dbg
);

  // Handshake: no back-pressure. ACTIVE qualifies DATA and CRC_VALID qualifies
  // CRC_IN, one bit per cycle each. ACTIVE wins when both are high.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CHECK  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] crc_r;
  logic [2:0] bit_cnt;
  logic       sticky;
  logic       mismatch;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r, input logic d);
    logic [7:0] nxt;
    logic       fb;
    fb     = d ^ r[0];
    nxt[7] = fb;
    for (int i = 0; i < 7; i++) begin
      nxt[i] = r[i+1] ^ (TAPS[i+1] & fb);
    end
    return nxt;
  endfunction

  assign mismatch    = (CRC_IN != crc_r[bit_cnt]);
  assign BUSY        = (state == S_DATA) || (state == S_CHECK);
  assign state_dbg   = state;
  assign bit_cnt_dbg = bit_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      crc_r   <= SEED;
      bit_cnt <= 3'd0;
      sticky  <= 1'b0;
      DONE    <= 1'b0;
      CRC_ERR <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (ACTIVE) begin
        if (state == S_DATA) begin
          crc_r <= lfsr_step(crc_r, DATA);
        end else begin
          // Frame start, or abort of a partial compare in CHECK.
          crc_r   <= lfsr_step(SEED, DATA);
          bit_cnt <= 3'd0;
          sticky  <= 1'b0;
        end
        state <= S_DATA;
      end else if (CRC_VALID && ((state == S_DATA) || (state == S_CHECK))) begin
        if (bit_cnt == 3'd7) begin
          state   <= S_RESULT;
          DONE    <= 1'b1;
          CRC_ERR <= sticky | mismatch;
          sticky  <= 1'b0;
          bit_cnt <= 3'd0;
        end else begin
          state   <= S_CHECK;
          sticky  <= sticky | mismatch;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: vector table of short frames, random payload frames
// against a bit-serial CRC model, plus abort, reset and priority sequences.
module tb_crc_check;

  localparam logic [7:0] SEED_C = 8'hD8;
  localparam logic [7:0] TAPS_C = 8'b1001_0001;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic       active;
  logic       crc_in;
  logic       crc_valid;
  logic       busy;
  logic       done;
  logic       crc_err;
  logic [1:0] state_dbg;
  logic [2:0] bit_cnt_dbg;

  int pass_cnt;
  int total_cnt;
  int done_cnt;

  typedef struct {
    logic [7:0] payload;
    int         nbits;
    logic [7:0] crc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[3];

  crc_check #(.SEED(SEED_C), .TAPS(TAPS_C)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .DATA        (data),
    .ACTIVE      (active),
    .CRC_IN      (crc_in),
    .CRC_VALID   (crc_valid),
    .BUSY        (busy),
    .DONE        (done),
    .CRC_ERR     (crc_err),
    .state_dbg   (state_dbg),
    .bit_cnt_dbg (bit_cnt_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_crc(input logic [7:0] p, input int n);
    logic [7:0] r;
    logic [7:0] taps_v;
    logic       fb;
    r      = SEED_C;
    taps_v = TAPS_C;
    for (int i = 0; i < n; i++) begin
      fb = p[i] ^ r[0];
      r  = {fb, r[7:1]} ^ (fb ? {1'b0, taps_v[7:1]} : 8'h00);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_payload(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      active = 1'b1;
      data   = p[i];
      tick();
    end
    active = 1'b0;
    data   = 1'b0;
  endtask

  task automatic send_crc(input logic [7:0] c, input int nb, input int gmin, input int gmax);
    int gap;
    for (int i = 0; i < nb; i++) begin
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) tick();
      crc_valid = 1'b1;
      crc_in    = c[i];
      tick();
      crc_valid = 1'b0;
      crc_in    = 1'b0;
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] p, input int n,
                           input logic [7:0] c, input logic exp_err,
                           input int gmin, input int gmax);
    int d0;
    d0 = done_cnt;
    send_payload(p, n);
    check({nm, " busy_data"}, busy, 1);
    send_crc(c, 8, gmin, gmax);
    check({nm, " done"}, done, 1);
    check({nm, " crc_err"}, crc_err, exp_err);
    check({nm, " state_result"}, state_dbg, 3);
    check({nm, " busy_result"}, busy, 0);
    tick();
    check({nm, " done_low"}, done, 0);
    check({nm, " err_hold"}, crc_err, exp_err);
    check({nm, " done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] c;
    int d0;
    pass_cnt  = 0;
    total_cnt = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    data      = 1'b0;
    active    = 1'b0;
    crc_in    = 1'b0;
    crc_valid = 1'b0;

    vecs[0] = '{payload: 8'h00, nbits: 1, crc: 8'h6C, exp_err: 1'b0};
    vecs[1] = '{payload: 8'h01, nbits: 1, crc: 8'hA4, exp_err: 1'b0};
    vecs[2] = '{payload: 8'h01, nbits: 1, crc: 8'hA5, exp_err: 1'b1};

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst crc_err", crc_err, 0);
    check("rst state", state_dbg, 0);
    check("rst bit_cnt", bit_cnt_dbg, 0);
    rst_n = 1'b1;
    tick();

    // Directed vector table
    for (int v = 0; v < 3; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].payload, vecs[v].nbits,
                vecs[v].crc, vecs[v].exp_err, 0, 0);
    end

    // Random payloads with gapped CRC bits; payload 4 carries one flipped CRC bit
    for (int f = 0; f < 10; f++) begin
      p = 8'($urandom_range(255, 0));
      c = model_crc(p, 8);
      if (f == 4) c[3] = ~c[3];
      run_frame($sformatf("rand%0d", f), p, 8, c, (f == 4), 1, 3);
    end

    // Abort: previous result is an error, partial compare carries a mismatch
    run_frame("pre_abort", 8'h01, 1, 8'hA5, 1'b1, 0, 0);
    d0 = done_cnt;
    send_payload(8'h3C, 8);
    send_crc(~model_crc(8'h3C, 8), 4, 0, 0);
    check("abort mid state", state_dbg, 2);
    check("abort mid cnt", bit_cnt_dbg, 4);
    send_payload(8'hC7, 8);
    check("abort state", state_dbg, 1);
    check("abort cnt", bit_cnt_dbg, 0);
    check("abort err_kept", crc_err, 1);
    check("abort no_done", done_cnt - d0, 0);
    send_crc(model_crc(8'hC7, 8), 8, 0, 1);
    check("abort new done", done, 1);
    check("abort new err", crc_err, 0);
    tick();

    // Asynchronous reset mid-CHECK after an erroring frame
    run_frame("pre_rst", 8'h01, 1, 8'hA5, 1'b1, 0, 0);
    d0 = done_cnt;
    send_payload(8'h5A, 8);
    send_crc(model_crc(8'h5A, 8), 3, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst crc_err", crc_err, 0);
    check("arst state", state_dbg, 0);
    #2;
    rst_n = 1'b1;
    tick();
    send_crc(8'hFF, 8, 0, 1);
    tick();
    check("arst no_done", done_cnt - d0, 0);
    check("arst idle busy", busy, 0);
    check("arst idle state", state_dbg, 0);

    // ACTIVE and CRC_VALID together: CRC bit ignored
    for (int i = 0; i < 3; i++) begin
      active    = 1'b1;
      data      = (i != 1);
      crc_valid = 1'b1;
      crc_in    = 1'b1;
      tick();
    end
    active    = 1'b0;
    crc_valid = 1'b0;
    data      = 1'b0;
    crc_in    = 1'b0;
    check("prio cnt", bit_cnt_dbg, 0);
    check("prio state", state_dbg, 1);
    send_crc(model_crc(8'h05, 3), 8, 0, 0);
    check("prio done", done, 1);
    check("prio err", crc_err, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
